// File: rtl/avg_pkg.sv
// Shared types and sizes for the AVG frame controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package avg_pkg;

  localparam int FB_WORDS = 307200;
  localparam int FB_AW    = 19;

  typedef enum logic [2:0] {
    IDLE,
    SWAP,
    CLEAR,
    KICK,
    GUARD,
    DRAW,
    DONE
  } state_t;

endpackage

// File: rtl/avg_clear_counter.sv
// Back-buffer clear address generator with terminal-count flag.
// Latency: address advances one word per enabled cycle; clear takes effect next cycle.
// Backpressure: none; wraps to zero on its own after the last word.
module avg_clear_counter
  import avg_pkg::*;
#(
  parameter int WORDS = FB_WORDS,
  parameter int AW    = FB_AW
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          enable,
  input  logic          clear,
  output logic [AW-1:0] addr,
  output logic          tc
);

  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;

  assign tc   = (addr_q == AW'(WORDS - 1));
  assign addr = addr_q;

  // Step through the buffer; return to zero after the last word so the
  // address idles at zero outside a clear pass.
  always_comb begin
    addr_d = addr_q;
    if (clear || (enable && tc)) begin
      addr_d = '0;
    end else if (enable) begin
      addr_d = addr_q + AW'(1);
    end
  end

  // Address register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/avg_frame_ctrl.sv
// Per-frame sequencer: buffer swap, back-buffer clear, AVG kick, line issue, completion.
// Latency: vsync to vggo is CLR_WORDS+2 cycles; line issue is combinational from queue/drawer status.
// Backpressure: lines issue only when queue is non-empty and drawer idle, never on consecutive cycles; vsync outside IDLE is dropped and counted.
module avg_frame_ctrl
  import avg_pkg::*;
#(
  parameter int CLR_WORDS = FB_WORDS,
  parameter int AW        = FB_AW
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          vsync,
  input  logic          avgHalted,
  output logic          vggo,
  input  logic          qEmpty,
  output logic          qRead,
  output logic          drawStart,
  input  logic          drawBusy,
  output logic          bufSel,
  output logic          clrWe,
  output logic [AW-1:0] clrAddr,
  output logic          frameDone,
  output logic [7:0]    overrunCnt
);

  state_t     state_q, state_d;
  logic       buf_sel_q, buf_sel_d;
  logic       issue_q, issue_d;
  logic [7:0] overrun_q, overrun_d;

  logic       issue;
  logic       clr_tc;
  logic       clr_en;

  assign clr_en = (state_q == CLEAR);

  avg_clear_counter #(
    .WORDS (CLR_WORDS),
    .AW    (AW)
  ) u_clear_counter (
    .clk    (clk),
    .rst_b  (rst_b),
    .enable (clr_en),
    .clear  (!clr_en),
    .addr   (clrAddr),
    .tc     (clr_tc)
  );

  // Next-state, strobes and bookkeeping. The drawer's busy flag lags
  // drawStart by a cycle, so the previous-cycle issue blocks a second issue
  // and also blocks the exit check.
  always_comb begin
    state_d   = state_q;
    buf_sel_d = buf_sel_q;
    overrun_d = overrun_q;
    issue     = 1'b0;
    vggo      = 1'b0;
    clrWe     = 1'b0;
    frameDone = 1'b0;

    if (vsync && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end

    case (state_q)
      IDLE:  if (vsync) state_d = SWAP;
      SWAP: begin
        buf_sel_d = ~buf_sel_q;
        state_d   = CLEAR;
      end
      CLEAR: begin
        clrWe = 1'b1;
        if (clr_tc) state_d = KICK;
      end
      KICK: begin
        vggo    = 1'b1;
        state_d = GUARD;
      end
      // The halt status register lags the kick, so it is not trusted here.
      GUARD: state_d = DRAW;
      DRAW: begin
        issue = !qEmpty && !drawBusy && !issue_q;
        if (avgHalted && qEmpty && !drawBusy && !issue && !issue_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        frameDone = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    issue_d = issue;
  end

  assign qRead      = issue;
  assign drawStart  = issue;
  assign bufSel     = buf_sel_q;
  assign overrunCnt = overrun_q;

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      buf_sel_q <= 1'b0;
      issue_q   <= 1'b0;
      overrun_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      buf_sel_q <= buf_sel_d;
      issue_q   <= issue_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_avg_frame_ctrl.sv
// Bench for avg_frame_ctrl with a small clear size.
// Latency: n/a.
// Backpressure: n/a.
module tb_avg_frame_ctrl;

  localparam int CW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          vsync = 1'b0;
  logic          avgHalted = 1'b0;
  logic          vggo;
  logic          qEmpty = 1'b1;
  logic          qRead;
  logic          drawStart;
  logic          drawBusy = 1'b0;
  logic          bufSel;
  logic          clrWe;
  logic [AW-1:0] clrAddr;
  logic          frameDone;
  logic [7:0]    overrunCnt;

  avg_frame_ctrl #(.CLR_WORDS(CW), .AW(AW)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .vsync      (vsync),
    .avgHalted  (avgHalted),
    .vggo       (vggo),
    .qEmpty     (qEmpty),
    .qRead      (qRead),
    .drawStart  (drawStart),
    .drawBusy   (drawBusy),
    .bufSel     (bufSel),
    .clrWe      (clrWe),
    .clrAddr    (clrAddr),
    .frameDone  (frameDone),
    .overrunCnt (overrunCnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a timeline counted from the vsync cycle.
  // t=1 swap, t=2..CW+1 clear words, t=CW+2 kick, t=CW+3 guard, t>=CW+4 draw.
  bit m_active, m_done, m_prev, m_buf;
  int m_t, m_ovr;

  // Observed outputs from the latest step, for the hand-written sequences.
  bit obs_vggo, obs_qrd, obs_clrwe, obs_done, obs_bsel;
  int obs_addr, obs_ovr;

  task automatic model_reset();
    m_active = 0; m_done = 0; m_prev = 0; m_buf = 0; m_t = 0; m_ovr = 0;
  endtask

  // One clock cycle: drive inputs, compare every output to the model, advance the model.
  task automatic step(input bit vs, input bit qe, input bit busy, input bit halt);
    bit e_vggo, e_issue, e_clrwe, e_done, e_exit;
    int e_addr;
    @(negedge clk);
    vsync = vs; qEmpty = qe; drawBusy = busy; avgHalted = halt;
    #1;
    e_vggo = 0; e_issue = 0; e_clrwe = 0; e_done = 0; e_exit = 0; e_addr = 0;
    if (m_done) begin
      e_done = 1;
    end else if (m_active) begin
      if (m_t >= 2 && m_t <= CW + 1) begin
        e_clrwe = 1;
        e_addr  = m_t - 2;
      end
      if (m_t == CW + 2) e_vggo = 1;
      if (m_t >= CW + 4) begin
        e_issue = !qe && !busy && !m_prev;
        e_exit  = halt && qe && !busy && !e_issue && !m_prev;
      end
    end
    obs_vggo = vggo; obs_qrd = qRead; obs_clrwe = clrWe; obs_done = frameDone;
    obs_bsel = bufSel; obs_addr = int'(clrAddr); obs_ovr = int'(overrunCnt);
    check("vggo", int'(vggo), int'(e_vggo));
    check("qRead", int'(qRead), int'(e_issue));
    check("drawStart", int'(drawStart), int'(e_issue));
    check("clrWe", int'(clrWe), int'(e_clrwe));
    check("clrAddr", int'(clrAddr), e_addr);
    check("frameDone", int'(frameDone), int'(e_done));
    check("bufSel", int'(bufSel), int'(m_buf));
    check("overrunCnt", int'(overrunCnt), m_ovr);
    if (vs && (m_active || m_done) && m_ovr < 255) m_ovr++;
    m_prev = e_issue;
    if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (m_t == 1) m_buf = !m_buf;
      if (e_exit) begin
        m_active = 0;
        m_done   = 1;
      end else if (m_t < CW + 4) begin
        m_t++;
      end
    end else if (vs) begin
      m_active = 1;
      m_t      = 1;
    end
  endtask

  task automatic do_reset();
    rst_b = 1'b0; vsync = 0; qEmpty = 1; drawBusy = 0; avgHalted = 0;
    #1;
    check("rst_bufSel", int'(bufSel), 0);
    check("rst_overrun", int'(overrunCnt), 0);
    check("rst_strobes", int'({vggo, qRead, drawStart, clrWe, frameDone}), 0);
    check("rst_clrAddr", int'(clrAddr), 0);
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  // Frame with halted AVG and empty queue; returns frameDone count and final bufSel.
  task automatic run_frame(output int dones, output bit bsel);
    dones = 0;
    step(1, 1, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 1);
      if (obs_done) dones++;
    end
    bsel = obs_bsel;
  endtask

  typedef struct {
    bit vs, qe, busy, halt;
    bit vggo, qrd, clrwe, done, bsel;
    int addr;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int dones, pulses, overlap, b2b, qcnt, busy_cnt, seen;
    bit bsel, prev_qrd;

    // Single frame after reset, AVG halted and queue empty throughout.
    for (int c = 0; c < 15; c++) begin
      tbl[c].vs    = (c == 0);
      tbl[c].qe    = 1;
      tbl[c].busy  = 0;
      tbl[c].halt  = 1;
      tbl[c].vggo  = (c == CW + 2);
      tbl[c].qrd   = 0;
      tbl[c].clrwe = (c >= 2 && c <= CW + 1);
      tbl[c].addr  = (c >= 2 && c <= CW + 1) ? c - 2 : 0;
      tbl[c].done  = (c == CW + 5);
      tbl[c].bsel  = (c >= 2);
    end

    do_reset();
    for (int c = 0; c < 15; c++) begin
      step(tbl[c].vs, tbl[c].qe, tbl[c].busy, tbl[c].halt);
      check($sformatf("tbl%0d_vggo", c), int'(obs_vggo), int'(tbl[c].vggo));
      check($sformatf("tbl%0d_qrd", c), int'(obs_qrd), int'(tbl[c].qrd));
      check($sformatf("tbl%0d_clrwe", c), int'(obs_clrwe), int'(tbl[c].clrwe));
      check($sformatf("tbl%0d_addr", c), obs_addr, tbl[c].addr);
      check($sformatf("tbl%0d_done", c), int'(obs_done), int'(tbl[c].done));
      check($sformatf("tbl%0d_bsel", c), int'(obs_bsel), int'(tbl[c].bsel));
    end

    // Three queued lines, drawer busy four cycles after each start.
    do_reset();
    qcnt = 3; busy_cnt = 0; pulses = 0; overlap = 0; b2b = 0; seen = 0; prev_qrd = 0;
    step(1, 0, 0, 1);
    for (int i = 0; i < 80 && seen == 0; i++) begin
      step(0, qcnt == 0, busy_cnt > 0, 1);
      if (obs_done) seen = 1;
      if (obs_qrd && busy_cnt > 0) overlap++;
      if (obs_qrd && prev_qrd) b2b++;
      prev_qrd = obs_qrd;
      if (obs_qrd) begin
        pulses++;
        if (qcnt > 0) qcnt--;
        busy_cnt = 4;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
    end
    check("lines_pulses", pulses, 3);
    check("lines_overlap", overlap, 0);
    check("lines_b2b", b2b, 0);
    check("lines_done", seen, 1);

    // Dropped vsyncs during CLEAR and DRAW, then saturation.
    do_reset();
    step(1, 1, 0, 0);
    for (int i = 1; i < 4; i++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 5; i < CW + 4; i++) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    check("ovr_two", obs_ovr, 2);
    for (int i = 0; i < 300; i++) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    check("ovr_sat", obs_ovr, 255);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 1);
      if (obs_done) seen++;
    end
    check("ovr_frame_done", seen, 1);

    // Reset in the middle of the clear pass.
    do_reset();
    step(1, 1, 0, 1);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      step(0, 1, 0, 1);
      if (obs_clrwe && obs_addr == 4) seen = 1;
    end
    check("midclr_reached", seen, 1);
    #1 rst_b = 1'b0;
    #1;
    check("midclr_clrWe", int'(clrWe), 0);
    check("midclr_bufSel", int'(bufSel), 0);
    model_reset();
    @(negedge clk);
    rst_b = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 1);
      if (obs_done) dones++;
    end
    check("midclr_no_done", dones, 0);
    step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    check("midclr_restart_bsel", int'(obs_bsel), 1);

    // Two consecutive frames.
    do_reset();
    run_frame(dones, bsel);
    check("f1_done", dones, 1);
    check("f1_bsel", int'(bsel), 1);
    run_frame(dones, bsel);
    check("f2_done", dones, 1);
    check("f2_bsel", int'(bsel), 0);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 30) == 0, ($urandom % 2) == 0, ($urandom % 4) == 0,
           ($urandom % 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
